// File: rtl/truth_table_checker.sv
// truth_table_checker
//   Exhaustive equivalence checker for two N-input, single-output Boolean
//   functions. When started, it presents every input vector 0..2^N-1 on vec.
//   It compares the two candidate outputs fa/fb, which may arrive LAT cycles
//   after the vector that produced them. It counts mismatches, records the
//   lowest mismatching vector and captures the truth table of candidate A.
//
// Ports
//   clk              rising-edge clock
//   reset_n          asynchronous active-low reset
//   start            begin a sweep (only honoured in IDLE)
//   vec              input vector driven to both candidates
//   vec_valid        vec carries a sweep index this cycle
//   fa, fb           candidate outputs, LAT cycles behind vec
//   busy             sweep or drain in progress
//   done             one-cycle pulse, results final
//   equal            no mismatch in the last sweep
//   mismatch_cnt     number of mismatching vectors (0..2^N)
//   first_bad        lowest mismatching vector (0 if none)
//   first_bad_valid  at least one mismatch seen
//   table_a          table_a[i] = fa for vec = i
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; results of the last sweep are held
// S_SWEEP | vec steps 0..2^N-1, one vector per cycle
// S_DRAIN | LAT cycles while the last delayed samples come back
// S_DONE  | single cycle, done pulse, then back to IDLE

module truth_table_checker #(
   parameter int N   = 3,
   parameter int LAT = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   output logic [N-1:0]      vec,
   output logic              vec_valid,
   input  logic              fa,
   input  logic              fb,
   output logic              busy,
   output logic              done,
   output logic              equal,
   output logic [N:0]        mismatch_cnt,
   output logic [N-1:0]      first_bad,
   output logic              first_bad_valid,
   output logic [2**N-1:0]   table_a
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SWEEP,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [2:0] DRAIN_LOAD = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

   state_t       state;
   state_t       state_nxt;
   logic [2:0]   drain_cnt;
   logic         last_vec;
   logic         dly_valid;
   logic [N-1:0] dly_idx;

   assign last_vec  = (vec == {N{1'b1}});
   assign vec_valid = (state == S_SWEEP);
   assign busy      = (state == S_SWEEP) || (state == S_DRAIN);
   assign done      = (state == S_DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_SWEEP;
         S_SWEEP: if (last_vec) state_nxt = (LAT > 0) ? S_DRAIN : S_DONE;
         S_DRAIN: if (drain_cnt == 3'd0) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         vec       <= '0;
         drain_cnt <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_SWEEP: begin
               // vec returns to 0 after the last index instead of wrapping mid-sweep
               vec       <= last_vec ? '0 : vec + N'(1);
               drain_cnt <= DRAIN_LOAD;
            end
            S_DRAIN: drain_cnt <= drain_cnt - 3'd1;
            default: vec <= '0;
         endcase
      end
   end

   // (valid, index) travel alongside the candidates' own LAT-cycle latency
   if (LAT == 0) begin : g_no_dly
      assign dly_valid = vec_valid;
      assign dly_idx   = vec;
   end else begin : g_dly
      logic [LAT-1:0] pipe_valid;
      logic [N-1:0]   pipe_idx [LAT];

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            pipe_valid <= '0;
            for (int k = 0; k < LAT; k++) pipe_idx[k] <= '0;
         end else begin
            pipe_valid[0] <= vec_valid;
            pipe_idx[0]   <= vec;
            for (int k = 1; k < LAT; k++) begin
               pipe_valid[k] <= pipe_valid[k-1];
               pipe_idx[k]   <= pipe_idx[k-1];
            end
         end
      end

      assign dly_valid = pipe_valid[LAT-1];
      assign dly_idx   = pipe_idx[LAT-1];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         equal           <= 1'b0;
         mismatch_cnt    <= '0;
         first_bad       <= '0;
         first_bad_valid <= 1'b0;
         table_a         <= '0;
      end else if ((state == S_IDLE) && start) begin
         equal           <= 1'b1;
         mismatch_cnt    <= '0;
         first_bad       <= '0;
         first_bad_valid <= 1'b0;
         table_a         <= '0;
      end else if (dly_valid) begin
         table_a[dly_idx] <= fa;
         if (fa != fb) begin
            mismatch_cnt <= mismatch_cnt + (N+1)'(1);
            equal        <= 1'b0;
            if (!first_bad_valid) begin
               first_bad       <= dly_idx;
               first_bad_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_truth_table_checker.sv
module tb_truth_table_checker;

   logic       clk;
   logic       reset_n;

   logic       start0, start2;
   logic [2:0] vec0, vec2;
   logic       vec_valid0, vec_valid2;
   logic       fa0, fb0, fa2, fb2;
   logic       busy0, busy2, done0, done2, equal0, equal2;
   logic [3:0] mismatch_cnt0, mismatch_cnt2;
   logic [2:0] first_bad0, first_bad2;
   logic       first_bad_valid0, first_bad_valid2;
   logic [7:0] table_a0, table_a2;

   int n_checks = 0;
   int n_errors = 0;
   int mode     = 1;
   bit sel      = 0;

   logic       fa2_p, fb2_p;
   logic [2:0] m_vec;
   logic       m_vec_valid, m_done, m_busy;

   truth_table_checker #(.N(3), .LAT(0)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .start(start0),
      .vec(vec0), .vec_valid(vec_valid0), .fa(fa0), .fb(fb0),
      .busy(busy0), .done(done0), .equal(equal0),
      .mismatch_cnt(mismatch_cnt0), .first_bad(first_bad0),
      .first_bad_valid(first_bad_valid0), .table_a(table_a0)
   );

   truth_table_checker #(.N(3), .LAT(2)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .start(start2),
      .vec(vec2), .vec_valid(vec_valid2), .fa(fa2), .fb(fb2),
      .busy(busy2), .done(done2), .equal(equal2),
      .mismatch_cnt(mismatch_cnt2), .first_bad(first_bad2),
      .first_bad_valid(first_bad_valid2), .table_a(table_a2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic f_pos(input logic [2:0] v);
      logic x, y, z;
      {x, y, z} = v;
      return (x | y | z) & (x | ~y | ~z) & (~x | y | z) & (~x | ~y | ~z);
   endfunction

   function automatic logic f_xor(input logic [2:0] v);
      return v[1] ^ v[0];
   endfunction

   always_comb begin
      fa0 = f_xor(vec0);
      fb0 = f_xor(vec0);
      case (mode)
         1: begin fa0 = f_pos(vec0); fb0 = f_xor(vec0); end
         2: begin fa0 = f_xor(vec0); fb0 = vec0[1] | vec0[0]; end
         3: begin fa0 = f_xor(vec0); fb0 = ~f_xor(vec0); end
         default: ;
      endcase
   end

   // two-stage registered candidates for the LAT=2 instance
   always_ff @(posedge clk) begin
      fa2_p <= f_pos(vec2);
      fb2_p <= f_xor(vec2);
      fa2   <= fa2_p;
      fb2   <= fb2_p;
   end

   assign m_vec       = sel ? vec2 : vec0;
   assign m_vec_valid = sel ? vec_valid2 : vec_valid0;
   assign m_done      = sel ? done2 : done0;
   assign m_busy      = sel ? busy2 : busy0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_start(input logic v);
      if (sel) start2 = v;
      else     start0 = v;
   endtask

   // Runs one sweep on the selected instance; cyc is the cycle (counted from
   // the start edge) in which done is first seen.
   task automatic run_sweep(input bit poke, output int cyc, output int nvec,
                            output bit seq_ok, output int ndone, output int nbusy_after);
      seq_ok      = 1'b1;
      nvec        = 0;
      ndone       = 0;
      nbusy_after = 0;
      cyc         = 0;
      @(negedge clk);
      set_start(1'b1);
      @(negedge clk);
      set_start(1'b0);
      while (cyc < 100) begin
         if (m_vec_valid) begin
            if (m_vec != 3'(nvec)) seq_ok = 1'b0;
            nvec++;
         end
         if (m_done) break;
         set_start(poke && (cyc == 3));
         @(negedge clk);
         cyc++;
      end
      if (m_done) ndone = 1;
      if (poke) set_start(1'b1);
      repeat (4) begin
         @(negedge clk);
         set_start(1'b0);
         if (m_done) ndone++;
         if (m_busy) nbusy_after++;
      end
   endtask

   int cyc, nvec, ndone, nbusy;
   bit seq_ok;
   int wait_cnt;

   initial begin
      reset_n = 1'b0;
      start0  = 1'b0;
      start2  = 1'b0;
      #12;
      check("rst_vec",      32'(vec0), 32'h0);
      check("rst_busy",     32'({busy0, done0, equal0, vec_valid0}), 32'h0);
      check("rst_cnt",      32'(mismatch_cnt0), 32'h0);
      check("rst_first",    32'({first_bad0, first_bad_valid0}), 32'h0);
      check("rst_table",    32'(table_a0), 32'h0);
      check("rst_lat2",     32'({busy2, done2, equal2, table_a2, mismatch_cnt2}), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      // T1: POS form vs y^z, combinational
      mode = 1; sel = 0;
      run_sweep(1'b0, cyc, nvec, seq_ok, ndone, nbusy);
      check("t1_done_cyc",  32'(cyc), 32'd8);
      check("t1_nvec",      32'(nvec), 32'd8);
      check("t1_seq",       32'(seq_ok), 32'd1);
      check("t1_ndone",     32'(ndone), 32'd1);
      check("t1_equal",     32'(equal0), 32'd1);
      check("t1_cnt",       32'(mismatch_cnt0), 32'd0);
      check("t1_fbv",       32'(first_bad_valid0), 32'd0);
      check("t1_first",     32'(first_bad0), 32'd0);
      check("t1_table",     32'(table_a0), 32'h66);

      // T2: y^z vs y|z
      mode = 2;
      run_sweep(1'b0, cyc, nvec, seq_ok, ndone, nbusy);
      check("t2_equal",     32'(equal0), 32'd0);
      check("t2_cnt",       32'(mismatch_cnt0), 32'd2);
      check("t2_first",     32'(first_bad0), 32'd3);
      check("t2_fbv",       32'(first_bad_valid0), 32'd1);
      check("t2_table",     32'(table_a0), 32'h66);

      // T3: every vector mismatches
      mode = 3;
      run_sweep(1'b0, cyc, nvec, seq_ok, ndone, nbusy);
      check("t3_cnt",       32'(mismatch_cnt0), 32'd8);
      check("t3_first",     32'(first_bad0), 32'd0);
      check("t3_fbv",       32'(first_bad_valid0), 32'd1);
      check("t3_equal",     32'(equal0), 32'd0);

      // T4: LAT=2 instance with twice-registered candidates
      sel = 1;
      run_sweep(1'b0, cyc, nvec, seq_ok, ndone, nbusy);
      check("t4_done_cyc",  32'(cyc), 32'd10);
      check("t4_seq",       32'(seq_ok), 32'd1);
      check("t4_nvec",      32'(nvec), 32'd8);
      check("t4_ndone",     32'(ndone), 32'd1);
      check("t4_equal",     32'(equal2), 32'd1);
      check("t4_cnt",       32'(mismatch_cnt2), 32'd0);
      check("t4_fbv",       32'(first_bad_valid2), 32'd0);
      check("t4_table",     32'(table_a2), 32'h66);

      // T5: start pulsed mid-sweep and during DONE
      sel = 0; mode = 1;
      run_sweep(1'b1, cyc, nvec, seq_ok, ndone, nbusy);
      check("t5_done_cyc",  32'(cyc), 32'd8);
      check("t5_nvec",      32'(nvec), 32'd8);
      check("t5_seq",       32'(seq_ok), 32'd1);
      check("t5_ndone",     32'(ndone), 32'd1);
      check("t5_no_restart",32'(nbusy), 32'd0);
      check("t5_table",     32'(table_a0), 32'h66);

      // T6: reset mid-sweep, then a clean T2 sweep
      mode = 2; sel = 0;
      @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      wait_cnt = 0;
      while ((vec0 != 3'd4) && (wait_cnt < 20)) begin
         @(negedge clk);
         wait_cnt++;
      end
      check("t6_reach_vec4", 32'(vec0), 32'd4);
      check("t6_pre_cnt",    32'(mismatch_cnt0), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_rst_vec",   32'({vec0, vec_valid0}), 32'h0);
      check("t6_rst_flags", 32'({busy0, done0, equal0}), 32'h0);
      check("t6_rst_cnt",   32'(mismatch_cnt0), 32'h0);
      check("t6_rst_first", 32'({first_bad0, first_bad_valid0}), 32'h0);
      check("t6_rst_table", 32'(table_a0), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      ndone = 0;
      repeat (12) begin
         @(negedge clk);
         if (done0 || busy0) ndone++;
      end
      check("t6_no_done",   32'(ndone), 32'd0);
      run_sweep(1'b0, cyc, nvec, seq_ok, ndone, nbusy);
      check("t6_done_cyc",  32'(cyc), 32'd8);
      check("t6_seq",       32'(seq_ok), 32'd1);
      check("t6_equal",     32'(equal0), 32'd0);
      check("t6_cnt",       32'(mismatch_cnt0), 32'd2);
      check("t6_first",     32'(first_bad0), 32'd3);
      check("t6_fbv",       32'(first_bad_valid0), 32'd1);
      check("t6_table",     32'(table_a0), 32'h66);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
